grey_sweep: RTL and testbench
=============================

# grey_sweep

Parametrised frame-sweep engine that reads every pixel of a packed-RGB image memory, converts it to a single greyscale value using a run-time selectable mode, and writes the result to a same-geometry output memory. It sits between the input-image BRAM (read port) and the output-image BRAM (write port) in the image pipeline. It replaces the free-running address counter and inline channel sum with a started, bounded, pipelined sweep that has a done indication.

## Interface
- WIDTH, 128: image width in pixels.
- HEIGHT, 128: image height in pixels.
- CH_BITS, 4: bits per colour channel. Input pixel is {R,G,B}, R in the MSBs.
- OUT_BITS, 8: greyscale output width. Constraint: CH_BITS <= OUT_BITS <= 2*CH_BITS.
- READ_LATENCY, 2: cycles from rd_addr to valid rd_data. Must be >= 1.
- Derived: NPIX = WIDTH*HEIGHT; ADDR_W = $clog2(NPIX).
- clk_100mhz  in  1  system clock.
- sys_rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a sweep. Ignored unless the block is in IDLE.
- mode  in  2  conversion mode, sampled on the accepted start.
- rd_addr  out  ADDR_W  input memory read address.
- rd_data  in  3*CH_BITS  input memory read data.
- wr_addr  out  ADDR_W  output memory write address.
- wr_data  out  OUT_BITS  greyscale pixel.
- wr_en  out  1  output memory write strobe.
- busy  out  1  high from the accepted start until the done pulse.
- done  out  1  one-cycle pulse after the last write.

## Operation
- FSM states and transitions:
  - IDLE -> RUN on start.
  - RUN -> DRAIN after rd_addr NPIX-1 is issued.
  - DRAIN -> DONE after the last write.
  - DONE -> IDLE after one cycle.
- RUN issues one address per cycle: 0, 1, ..., NPIX-1. The address never reaches NPIX and wraps to 0 only at the next start.
- A valid tag enters a READ_LATENCY-deep shift register alongside each issued address. When the tag exits, rd_data is captured, converted, and registered into wr_data, wr_addr and wr_en in one stage.
- Channel expansion: each channel is replicated to fill OUT_BITS, keeping the MSBs. For CH_BITS=4 and OUT_BITS=8: e = {c,c}, so 0xF becomes 0xFF and 0x9 becomes 0x99.
- mode 0, luma: (77*eR + 150*eG + 29*eB) >> 8. The intermediate is OUT_BITS+8 bits wide; no saturation is needed.
- mode 1, max: max(eR, eG, eB).
- mode 2, mean: ((eR + eG + eB) * 171) >> 9, truncated.
- mode 3, green passthrough: eG.
- mode is latched at start. Changes to mode mid-sweep have no effect on the sweep in progress.
- start while busy=1 is ignored. It is not queued.
- sys_rst asserted at any point, including mid-sweep:
  - all outputs return to 0 immediately and the state returns to IDLE;
  - the pipeline tags are cleared, so no partial write completes after reset;
  - a new start is required.
- Reset values: rd_addr=0, wr_addr=0, wr_data=0, wr_en=0, busy=0, done=0.

## Timing
- Accepted start at cycle 0:
  - busy=1 and rd_addr=0 from cycle 1;
  - rd_addr=k at cycle 1+k.
- rd_data for address k is valid at cycle 1+k+READ_LATENCY.
- The write for address k (wr_en=1, wr_addr=k) occurs at cycle 2+k+READ_LATENCY.
- Throughput is 1 pixel/cycle; wr_en stays high for exactly NPIX consecutive cycles.
- The last write is at cycle 1+NPIX+READ_LATENCY. done=1 and busy=1 at cycle 2+NPIX+READ_LATENCY; busy=0 the following cycle.
- Sweep length is NPIX+READ_LATENCY+3 cycles, counted from start to return to IDLE.
- A start arriving in the same cycle as done is ignored, because the block is not yet in IDLE. The earliest accepted restart is the cycle after done.
- rd_addr holds NPIX-1 during DRAIN and resets to 0 in IDLE.
- wr_data and wr_addr hold their last values when wr_en=0.

## Test plan
- Full-white frame: WIDTH=4, HEIGHT=2, all rd_data=0xFFF, mode 0. Expect 8 writes of 0xFF at addresses 0..7 on consecutive cycles, and the first write exactly READ_LATENCY+2 cycles after start.
- Per-mode arithmetic: pixel 0xF00 in mode 0 gives 76. Pixel 0x391 in mode 1 gives 0x99. Pixel 0xAAA in mode 2 gives 170. Pixel 0x3C5 in mode 3 gives 0xCC.
- Memory model with rd_data = address pattern, READ_LATENCY swept over 1, 2 and 3: every written value matches a golden model for its own address, with no off-by-one skew.
- Control handshake:
  - start during busy produces no extra writes and unchanged timing;
  - a mode change mid-sweep leaves outputs in the latched mode;
  - done is a single pulse and busy falls the cycle after it.
- Asynchronous sys_rst asserted at pixel 3 of 8: all outputs are 0 immediately and no further wr_en occurs. A subsequent start produces a complete 8-pixel sweep from address 0.
- Default parameters (128x128): exactly 16384 writes, final wr_addr=16383, rd_addr never exceeds 16383.

Source files
------------

// File: rtl/grey_sweep.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | grey_sweep: bounded, pipelined RGB-to-greyscale frame sweep with done pulse  |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module grey_sweep #(
  parameter int WIDTH        = 128,
  parameter int HEIGHT       = 128,
  parameter int CH_BITS      = 4,
  parameter int OUT_BITS     = 8,
  parameter int READ_LATENCY = 2,
  localparam int NPIX        = WIDTH * HEIGHT,
  localparam int ADDR_W      = $clog2(NPIX)
) (
  input  logic                   clk_100mhz,
  input  logic                   sys_rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [3*CH_BITS-1:0]   rd_data,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [OUT_BITS-1:0]    wr_data,
  output logic                   wr_en,
  output logic                   busy,
  output logic                   done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam int LUMA_W = OUT_BITS + 8;
  localparam int MEAN_W = OUT_BITS + 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         rd_addr_q, rd_addr_d;
  logic [1:0]                mode_q, mode_d;
  logic [READ_LATENCY-1:0]   tag_q;
  logic [ADDR_W-1:0]         wcnt_q;
  logic [ADDR_W-1:0]         wr_addr_q;
  logic [OUT_BITS-1:0]       wr_data_q;
  logic                      wr_en_q;
  logic                      issue;
  logic                      tag_exit;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    mode_d    = mode_q;
    issue     = 1'b0;
    case (state_q)
      S_IDLE: begin
        rd_addr_d = '0;
        if (start) begin
          state_d = S_RUN;
          mode_d  = mode;
        end
      end
      S_RUN: begin
        issue = 1'b1;
        if (rd_addr_q == LAST_ADDR) state_d = S_DRAIN;
        else                        rd_addr_d = rd_addr_q + ADDR_W'(1);
      end
      S_DRAIN: begin
        if (wr_en_q && (wr_addr_q == LAST_ADDR)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d   = S_IDLE;
        rd_addr_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      mode_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      mode_q    <= mode_d;
    end
  end

  // Valid tags travel with the read latency so the write lines up with rd_data.
  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_exit = tag_q[READ_LATENCY-1];

  logic [2*CH_BITS-1:0] rep_r, rep_g, rep_b;
  logic [OUT_BITS-1:0]  e_r, e_g, e_b, g_luma, g_max, g_mean, g_sel;
  logic [LUMA_W-1:0]    luma_sum;
  logic [MEAN_W-1:0]    mean_prod;

  // Channel replication keeps the MSBs so full-scale maps to full-scale.
  assign rep_r = {2{rd_data[3*CH_BITS-1 -: CH_BITS]}};
  assign rep_g = {2{rd_data[2*CH_BITS-1 -: CH_BITS]}};
  assign rep_b = {2{rd_data[CH_BITS-1   -: CH_BITS]}};
  assign e_r   = OUT_BITS'(rep_r >> (2*CH_BITS - OUT_BITS));
  assign e_g   = OUT_BITS'(rep_g >> (2*CH_BITS - OUT_BITS));
  assign e_b   = OUT_BITS'(rep_b >> (2*CH_BITS - OUT_BITS));

  assign luma_sum  = LUMA_W'(77) * LUMA_W'(e_r) + LUMA_W'(150) * LUMA_W'(e_g)
                   + LUMA_W'(29) * LUMA_W'(e_b);
  assign g_luma    = OUT_BITS'(luma_sum >> 8);
  assign mean_prod = (MEAN_W'(e_r) + MEAN_W'(e_g) + MEAN_W'(e_b)) * MEAN_W'(171);
  assign g_mean    = OUT_BITS'(mean_prod >> 9);

  always_comb begin
    g_max = e_r;
    if (e_g > g_max) g_max = e_g;
    if (e_b > g_max) g_max = e_b;
  end

  always_comb begin
    g_sel = g_luma;
    case (mode_q)
      2'd0:    g_sel = g_luma;
      2'd1:    g_sel = g_max;
      2'd2:    g_sel = g_mean;
      default: g_sel = e_g;
    endcase
  end

  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      wcnt_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      wr_en_q <= tag_exit;
      if (state_q == S_IDLE) wcnt_q <= '0;
      else if (tag_exit)     wcnt_q <= wcnt_q + ADDR_W'(1);
      if (tag_exit) begin
        wr_addr_q <= wcnt_q;
        wr_data_q <= g_sel;
      end
    end
  end

  assign rd_addr = rd_addr_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_en   = wr_en_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_grey_sweep.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_grey_sweep: directed-vector bench for grey_sweep (4x2 frames, RL 1..3,     |
// | plus one default 128x128 sweep). Revision: 1.0                               |
// +----------------------------------------------------------------------------+
module tb_grey_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  mode;
  logic [2:0]  st;
  logic        stb;
  logic        pat;
  logic [11:0] cpix;
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int npass = 0;
  int ntotal = 0;

  logic [2:0][2:0]  ra;
  logic [2:0][11:0] rdd;
  logic [2:0][2:0]  wa_o;
  logic [2:0][7:0]  wd_o;
  logic [2:0]       wen, bsy, dn;

  int wn [3];
  int wa [3][1024];
  int wd [3][1024];
  int wc [3][1024];

  function automatic logic [11:0] pix_of(input int a);
    int v;
    v = (a * 419 + 53) % 4096;
    return v[11:0];
  endfunction

  function automatic int grey(input logic [11:0] p, input int m);
    int r, g, b, mx;
    r = int'(p[11:8]) * 17;
    g = int'(p[7:4]) * 17;
    b = int'(p[3:0]) * 17;
    case (m)
      0: return (77 * r + 150 * g + 29 * b) >> 8;
      1: begin
        mx = r;
        if (g > mx) mx = g;
        if (b > mx) mx = b;
        return mx;
      end
      2: return ((r + g + b) * 171) >> 9;
      default: return g;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [2:0] dl0, dl1, dl2;
    grey_sweep #(.WIDTH(4), .HEIGHT(2), .CH_BITS(4), .OUT_BITS(8), .READ_LATENCY(g + 1)) u_dut (
      .clk_100mhz(clk), .sys_rst(rst), .start(st[g]), .mode(mode),
      .rd_addr(ra[g]), .rd_data(rdd[g]), .wr_addr(wa_o[g]), .wr_data(wd_o[g]),
      .wr_en(wen[g]), .busy(bsy[g]), .done(dn[g])
    );
    always @(posedge clk) begin
      dl0 <= ra[g];
      dl1 <= dl0;
      dl2 <= dl1;
    end
    assign rdd[g] = pat ? cpix : pix_of(int'(g == 0 ? dl0 : (g == 1 ? dl1 : dl2)));
    initial wn[g] = 0;
    always @(negedge clk) begin
      if (wen[g]) begin
        if (wn[g] < 1024) begin
          wa[g][wn[g]] = int'(wa_o[g]);
          wd[g][wn[g]] = int'(wd_o[g]);
          wc[g][wn[g]] = cyc;
        end
        wn[g] = wn[g] + 1;
      end
    end
  end

  logic [13:0] rab, wab, db0, db1;
  logic [11:0] rdb;
  logic [7:0]  wdb;
  logic        wenb, bsyb, dnb;
  int nbw = 0, errb = 0, lastb = -1, maxra = 0;

  grey_sweep #(.WIDTH(128), .HEIGHT(128), .CH_BITS(4), .OUT_BITS(8), .READ_LATENCY(2)) u_big (
    .clk_100mhz(clk), .sys_rst(rst), .start(stb), .mode(mode),
    .rd_addr(rab), .rd_data(rdb), .wr_addr(wab), .wr_data(wdb),
    .wr_en(wenb), .busy(bsyb), .done(dnb)
  );
  always @(posedge clk) begin
    db0 <= rab;
    db1 <= db0;
  end
  assign rdb = pix_of(int'(db1));
  always @(negedge clk) begin
    if (int'(rab) > maxra) maxra = int'(rab);
    if (wenb) begin
      if (int'(wab) != nbw || int'(wdb) != grey(pix_of(int'(wab)), 0)) errb++;
      lastb = int'(wab);
      nbw++;
    end
  end

  task automatic sweep(input int i, input int m, input bit poke, output int s, output int base);
    int dc;
    bit got;
    got = 1'b0;
    dc = 0;
    base = wn[i];
    @(posedge clk); #1;
    st[i] = 1'b1;
    mode = 2'(m);
    s = cyc;
    @(posedge clk); #1;
    st[i] = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (dn[i]) begin
        got = 1'b1;
        dc = cyc;
      end
    end
    chk("done_seen", int'(got), 1);
    chk("done_cycle", dc - s, 11 + i);
    chk("busy_at_done", int'(bsy[i]), 1);
    if (poke) st[i] = 1'b1;
    @(posedge clk); #1;
    st[i] = 1'b0;
    @(negedge clk);
    chk("done_pulse_width", int'(dn[i]), 0);
    chk("busy_after_done", int'(bsy[i]), 0);
  endtask

  task automatic check_writes(input int i, input int base, input int s, input int m);
    chk("write_count", wn[i] - base, 8);
    for (int k = 0; k < 8; k++) begin
      chk("wr_addr", wa[i][base + k], k);
      chk("wr_data", wd[i][base + k], grey(pat ? cpix : pix_of(k), m));
      chk("wr_cycle", wc[i][base + k] - s, 3 + i + k);
    end
  endtask

  task automatic chk_zero(input string nm, input int i);
    chk({nm, "_rd_addr"}, int'(ra[i]), 0);
    chk({nm, "_wr_addr"}, int'(wa_o[i]), 0);
    chk({nm, "_wr_data"}, int'(wd_o[i]), 0);
    chk({nm, "_wr_en"}, int'(wen[i]), 0);
    chk({nm, "_busy"}, int'(bsy[i]), 0);
    chk({nm, "_done"}, int'(dn[i]), 0);
  endtask

  typedef struct {
    logic [11:0] pix;
    logic [1:0]  md;
    logic [7:0]  exp;
  } vec_t;

  vec_t vt [10];

  initial begin
    int s, base, nb, dc;
    bit got;

    vt[0] = '{12'hF00, 2'd0, 8'd76};
    vt[1] = '{12'h391, 2'd1, 8'h99};
    vt[2] = '{12'hAAA, 2'd2, 8'd170};
    vt[3] = '{12'h3C5, 2'd3, 8'hCC};
    vt[4] = '{12'hFFF, 2'd2, 8'd255};
    vt[5] = '{12'h0F0, 2'd0, 8'd149};
    vt[6] = '{12'h00F, 2'd0, 8'd28};
    vt[7] = '{12'h123, 2'd2, 8'd34};
    vt[8] = '{12'h5A3, 2'd1, 8'hAA};
    vt[9] = '{12'h000, 2'd0, 8'd0};

    rst = 1'b1; st = '0; stb = 1'b0; mode = 2'd0; pat = 1'b1; cpix = 12'h000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset", 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full-white frame: latency, address order and back-to-back writes.
    cpix = 12'hFFF;
    sweep(1, 0, 1'b0, s, base);
    check_writes(1, base, s, 0);

    for (int v = 0; v < 10; v++) begin
      cpix = vt[v].pix;
      sweep(1, int'(vt[v].md), 1'b0, s, base);
      chk("vec_count", wn[1] - base, 8);
      for (int k = 0; k < 8; k++) chk("vec_data", wd[1][base + k], int'(vt[v].exp));
    end

    // Address-pattern memory with READ_LATENCY 1, 2, 3.
    pat = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sweep(i, i, 1'b0, s, base);
      check_writes(i, base, s, i);
    end

    // Start and mode change while busy, plus a start coinciding with done.
    fork
      sweep(1, 1, 1'b1, s, base);
      begin
        repeat (4) @(posedge clk);
        #2;
        st[1] = 1'b1;
        mode = 2'd3;
        @(posedge clk); #2;
        st[1] = 1'b0;
      end
    join
    check_writes(1, base, s, 1);
    repeat (10) @(negedge clk);
    chk("no_extra_writes", wn[1] - base, 8);

    // Asynchronous reset at pixel 3 of 8.
    @(posedge clk); #1;
    st[1] = 1'b1;
    mode = 2'd0;
    @(posedge clk); #1;
    st[1] = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 30 && !got; t++) begin
      @(negedge clk);
      if (ra[1] == 3'd3) got = 1'b1;
    end
    chk("reach_pixel3", int'(got), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst", 1);
    nb = wn[1];
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("no_write_after_rst", wn[1] - nb, 0);
    chk("idle_after_rst", int'(bsy[1]), 0);
    sweep(1, 0, 1'b0, s, base);
    check_writes(1, base, s, 0);

    // Default 128x128 geometry.
    @(posedge clk); #1;
    stb = 1'b1;
    mode = 2'd0;
    s = cyc;
    @(posedge clk); #1;
    stb = 1'b0;
    got = 1'b0;
    dc = 0;
    for (int t = 0; t < 17000 && !got; t++) begin
      @(negedge clk);
      if (dnb) begin
        got = 1'b1;
        dc = cyc;
      end
    end
    chk("big_done_seen", int'(got), 1);
    chk("big_done_cycle", dc - s, 16388);
    chk("big_write_count", nbw, 16384);
    chk("big_last_wr_addr", lastb, 16383);
    chk("big_max_rd_addr", maxra, 16383);
    chk("big_data_errors", errb, 0);
    @(negedge clk);
    chk("big_busy_after", int'(bsyb), 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
`default_nettype wire
